// File: rtl/timer_tick_master.sv
// timer_tick_master: Avalon-MM initiator for the interval-timer slave.
// Programs the period, starts the timer in continuous/IRQ mode, then acknowledges
// each timeout and emits a one-cycle frame tick.
// Optional build macro TIMER_TICK_SNAPSHOT_EN: snapshot the timer counter on every
// serviced timeout and expose it on snap_value.
module timer_tick_master #(
  parameter logic [31:0] PERIOD = 32'd833332,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic [2:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [15:0]      writedata,
  input  logic [15:0]      readdata,
  input  logic             irq,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             running
`ifdef TIMER_TICK_SNAPSHOT_EN
  ,
  output logic [31:0]      snap_value
`endif
);

  typedef enum logic [3:0] {
    IDLE, CFG_PL, CFG_PH, CFG_CTRL, RUN, ACK, HOLD, HALT
`ifdef TIMER_TICK_SNAPSHOT_EN
    , SNAP_WR, SNAP_RL, SNAP_RLD, SNAP_RHD
`endif
  } state_t;

  state_t state;
  logic   stop_seen;
  logic   halt_req;

  // A stop seen while busy is remembered until the next safe point to halt.
  assign halt_req = stop | stop_seen;

`ifndef TIMER_TICK_SNAPSHOT_EN
  // readdata is only consumed by the snapshot path.
  logic unused_rd;
  assign unused_rd = ^readdata;
`endif

  // Sequencer: bus outputs are registered for the state being entered, so each
  // write is presented for exactly the one cycle its state occupies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stop_seen  <= 1'b0;
      address    <= 3'd0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= 16'h0000;
      tick       <= 1'b0;
      tick_count <= '0;
      running    <= 1'b0;
`ifdef TIMER_TICK_SNAPSHOT_EN
      snap_value <= 32'd0;
`endif
    end else begin
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      tick       <= 1'b0;
      if (stop && state != IDLE) stop_seen <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state      <= CFG_PL;
          tick_count <= '0;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd2;
          writedata  <= PERIOD[15:0];
        end
        CFG_PL: begin
          state      <= CFG_PH;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd3;
          writedata  <= PERIOD[31:16];
        end
        CFG_PH: begin
          state      <= CFG_CTRL;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd1;
          writedata  <= 16'h0007;
        end
        CFG_CTRL: begin
          running <= 1'b1;
          if (halt_req) begin
            state      <= HALT;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            address    <= 3'd1;
            writedata  <= 16'h0008;
          end else begin
            state <= RUN;
          end
        end
        RUN: if (stop) begin
          state      <= HALT;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd1;
          writedata  <= 16'h0008;
        end else if (irq) begin
          state      <= ACK;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd0;
          writedata  <= 16'h0000;
        end
        ACK: begin
          tick       <= 1'b1;
          tick_count <= tick_count + CNT_W'(1);
`ifdef TIMER_TICK_SNAPSHOT_EN
          state      <= SNAP_WR;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd4;
          writedata  <= 16'h0000;
`else
          state      <= HOLD;
`endif
        end
`ifdef TIMER_TICK_SNAPSHOT_EN
        SNAP_WR: begin
          state      <= SNAP_RL;
          chipselect <= 1'b1;
          address    <= 3'd4;
        end
        SNAP_RL: begin
          state      <= SNAP_RLD;
          chipselect <= 1'b1;
          address    <= 3'd5;
        end
        SNAP_RLD: begin
          snap_value[15:0] <= readdata;
          state            <= SNAP_RHD;
        end
        SNAP_RHD: begin
          snap_value[31:16] <= readdata;
          state             <= HOLD;
        end
`endif
        HOLD: if (halt_req) begin
          state      <= HALT;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= 3'd1;
          writedata  <= 16'h0008;
        end else begin
          state <= RUN;
        end
        HALT: begin
          running   <= 1'b0;
          stop_seen <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/timer_tick_master.md
Name: timer_tick_master

Overview:
- Avalon-MM initiator that drives the 16-bit-data, 3-bit-address interval-timer slave used in the game system.
- Programs the timer period, starts it in continuous/IRQ mode, then services each timeout: acknowledges the status register and emits a one-cycle frame tick to game logic.
- Sits between the timer slave's s1 port and the pong frame-update logic, so no CPU is needed for frame pacing.

Parameters:
- PERIOD, 32'd833332, timer load value; tick interval is PERIOD+1 clocks (60 Hz at 50 MHz).
- CNT_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begin configuration (ignored unless IDLE)
- stop  in  1  pulse; halt timer (ignored in IDLE)
- address  out  3  to timer slave
- chipselect  out  1  to timer slave
- write_n  out  1  to timer slave, active low
- writedata  out  16  to timer slave
- readdata  in  16  from timer slave; valid 1 cycle after address is presented
- irq  in  1  timer interrupt, level
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  CNT_W  serviced timeouts since start, wraps
- running  out  1  high from CFG_CTRL completion until stop completes

Behaviour:
- All outputs are registered. Reset values: address=0, chipselect=0, write_n=1, writedata=0, tick=0, tick_count=0, running=0. State=IDLE.
- Each bus write occupies exactly one cycle: chipselect=1, write_n=0. The slave has no waitrequest. Outside bus cycles: chipselect=0, write_n=1, address and writedata hold their last values.
- States and transitions:
  - IDLE: on start -> CFG_PL.
  - CFG_PL: write addr 2 = PERIOD[15:0] -> CFG_PH.
  - CFG_PH: write addr 3 = PERIOD[31:16] -> CFG_CTRL.
  - CFG_CTRL: write addr 1 = 16'h0007 (ITO|CONT|START); running<=1 -> RUN.
  - RUN: stop has priority -> HALT. Else if irq=1 -> ACK.
  - ACK: write addr 0 = 16'h0000 (clear TO); tick<=1; tick_count<=tick_count+1 -> HOLD.
  - HOLD: one idle cycle, so that the registered irq has deasserted before it is resampled -> RUN (or HALT if stop was seen).
  - HALT: write addr 1 = 16'h0008 (STOP, ITO=0); running<=0 -> IDLE.
- Latency:
  - start to first write: 1 cycle.
  - irq rising in RUN to ACK write: 1 cycle.
  - tick is high in the cycle after ACK.
- stop during CFG_* is latched. The configuration sequence completes, then the block goes to HALT instead of RUN; no tick is produced.
- stop arriving in the same cycle as irq in RUN: HALT wins. The timeout is not acknowledged and tick_count does not change.
- start while not IDLE is ignored. start and stop in the same cycle in IDLE: start is taken and stop is dropped.
- tick_count wraps from all-ones to 0 silently.
- Reset mid-sequence returns to IDLE immediately and clears all outputs. The timer slave is reset by the same system reset.
- irq held high through HOLD (timer expired again during the acknowledge) is serviced on the next RUN cycle. No timeout is lost.

Optional Feature:
- Macro TIMER_TICK_SNAPSHOT_EN.
- Defined: adds output snap_value[31:0] (reset 0) and states SNAP_WR, SNAP_RL, SNAP_RLD, SNAP_RHD, inserted between ACK and HOLD.
  - SNAP_WR: write addr 4 = 0.
  - SNAP_RL: read addr 4 (chipselect=1, write_n=1).
  - SNAP_RLD: capture readdata into snap_value[15:0] and present addr 5.
  - SNAP_RHD: capture readdata into snap_value[31:16].
  - tick is still asserted in the cycle after ACK.
- Undefined: no snapshot states, no snap_value port.

Test Plan:
- Reset then idle 10 cycles -> chipselect=0, write_n=1, tick=0, tick_count=0, running=0 throughout.
- PERIOD=9, start pulse against a behavioural timer slave -> writes, one per consecutive cycle: (2,0x0009), (3,0x0000), (1,0x0007); then running=1.
- Continue 50 cycles -> tick pulses exactly every 10 cycles; each tick is preceded by a write (0,0x0000); tick_count=5.
- stop while RUN -> write (1,0x0008) on the next cycle, running=0, no further ticks, IDLE.
- Assert reset during CFG_PH -> outputs return to reset values in the same cycle; a later start reissues the full sequence from CFG_PL.
- With TIMER_TICK_SNAPSHOT_EN, slave counter at 7 when the snap write lands -> snap_value=32'd7 and tick spacing is unchanged.
